// File: rtl/crc_arb_if.sv
// crc_arb_if: requester-side bundle of the shared CRC-8 engine (requests, clears, grants, contexts).
// Requests are level and held until gnt_o; the engine drives gnt_o/done_o/crc_o/busy_o back.
interface crc_arb_if #(
  parameter int REQ_NUM = 4
);
  logic [REQ_NUM-1:0]   req_i;
  logic [8*REQ_NUM-1:0] data_i;
  logic [REQ_NUM-1:0]   clr_i;
  logic [7:0]           init_i;
  logic [REQ_NUM-1:0]   gnt_o;
  logic [REQ_NUM-1:0]   done_o;
  logic [8*REQ_NUM-1:0] crc_o;
  logic                 busy_o;

  modport master (
    output req_i, data_i, clr_i, init_i,
    input  gnt_o, done_o, crc_o, busy_o
  );

  modport slave (
    input  req_i, data_i, clr_i, init_i,
    output gnt_o, done_o, crc_o, busy_o
  );
endinterface

// File: rtl/crc_arb.sv
// crc_arb: shared CRC-8 (poly 0x07) engine, round-robin arbitration, or fixed priority with CRC_ARB_PRIO_EN.
// done_o 5 cycles after gnt_o, one byte per 6 cycles; requesters hold req_i until granted, ignored while busy.
module crc_arb #(
  parameter int REQ_NUM = 4
) (
  input  logic      clk_i,
  input  logic      rst_i,
  crc_arb_if.slave  bus
);
  localparam int IW = $clog2(REQ_NUM);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SHIFT1 = 3'd1,
    SHIFT2 = 3'd2,
    SHIFT3 = 3'd3,
    SHIFT4 = 3'd4,
    DONE   = 3'd5
  } state_t;

  state_t              state_q;
  state_t              state_d;
  logic [7:0]          ctx_q [REQ_NUM];
  logic [7:0]          work_q;
  logic [7:0]          byte_q;
  logic [IW-1:0]       idx_q;
`ifndef CRC_ARB_PRIO_EN
  logic [IW-1:0]       last_q;
`endif
  logic [REQ_NUM-1:0]  elig;
  logic                win_vld;
  logic [IW-1:0]       win_idx;
  logic                abort;
  logic [1:0]          bits;
  logic [7:0]          step_crc;

  function automatic logic [7:0] crc_bit(input logic [7:0] c, input logic b);
    logic fb;
    fb = c[7] ^ b;
    return {c[6:0], 1'b0} ^ (fb ? 8'h07 : 8'h00);
  endfunction

  // A same-cycle clear beats the request.
  assign elig  = bus.req_i & ~bus.clr_i;
  assign abort = (state_q != IDLE) && bus.clr_i[idx_q];

  always_comb begin
    win_vld = 1'b0;
    win_idx = '0;
`ifdef CRC_ARB_PRIO_EN
    for (int i = REQ_NUM - 1; i >= 0; i--) begin
      if (elig[i]) begin
        win_vld = 1'b1;
        win_idx = IW'(i);
      end
    end
`else
    for (int i = REQ_NUM; i >= 1; i--) begin
      logic [IW-1:0] cand;
      cand = IW'((int'(last_q) + i) % REQ_NUM);
      if (elig[cand]) begin
        win_vld = 1'b1;
        win_idx = cand;
      end
    end
`endif
  end

  always_comb begin
    case (state_q)
      SHIFT1:  bits = byte_q[7:6];
      SHIFT2:  bits = byte_q[5:4];
      SHIFT3:  bits = byte_q[3:2];
      default: bits = byte_q[1:0];
    endcase
    step_crc = crc_bit(crc_bit(work_q, bits[1]), bits[0]);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (win_vld) state_d = SHIFT1;
      SHIFT1:  state_d = SHIFT2;
      SHIFT2:  state_d = SHIFT3;
      SHIFT3:  state_d = SHIFT4;
      SHIFT4:  state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (abort) state_d = IDLE;
  end

  always_comb begin
    bus.gnt_o  = '0;
    bus.done_o = '0;
    bus.busy_o = (state_q != IDLE);
    if (state_q == IDLE && win_vld) bus.gnt_o[win_idx] = 1'b1;
    if (state_q == DONE && !abort)  bus.done_o[idx_q]  = 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      work_q <= '0;
      byte_q <= '0;
      idx_q  <= '0;
`ifndef CRC_ARB_PRIO_EN
      last_q <= IW'(REQ_NUM - 1);
`endif
    end else if (state_q == IDLE && win_vld) begin
      byte_q <= bus.data_i[8*win_idx +: 8];
      idx_q  <= win_idx;
      work_q <= ctx_q[win_idx];
`ifndef CRC_ARB_PRIO_EN
      last_q <= win_idx;
`endif
    end else if (state_q inside {SHIFT1, SHIFT2, SHIFT3, SHIFT4}) begin
      work_q <= step_crc;
    end
  end

  // The result commits on the edge into DONE so crc_o already shows it while done_o pulses;
  // a clear of the active requester in DONE still overwrites it with init_i on the next edge.
  always_ff @(posedge clk_i) begin
    for (int k = 0; k < REQ_NUM; k++) begin
      if (rst_i) begin
        ctx_q[k] <= '0;
      end else if (bus.clr_i[k]) begin
        ctx_q[k] <= bus.init_i;
      end else if (state_q == SHIFT4 && idx_q == IW'(k)) begin
        ctx_q[k] <= step_crc;
      end
    end
  end

  always_comb begin
    for (int k = 0; k < REQ_NUM; k++) begin
      bus.crc_o[8*k +: 8] = ctx_q[k];
    end
  end
endmodule

// File: tb/tb_crc_arb.sv
// tb_crc_arb: vector table, directed corner sequences and a randomized run against a byte-level model.
module tb_crc_arb;
  localparam int N = 4;

  logic clk_i = 1'b0;
  logic rst_i = 1'b1;
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;

  crc_arb_if #(.REQ_NUM(N)) bus ();
  crc_arb #(.REQ_NUM(N)) dut (.clk_i(clk_i), .rst_i(rst_i), .bus(bus));

  always #5 clk_i = ~clk_i;
  always @(posedge clk_i) cyc <= cyc + 1;

  typedef struct {
    int         k;
    logic [7:0] init;
    logic [7:0] dat;
    logic [7:0] exp;
  } vec_t;
  vec_t vecs [6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic do_reset();
    rst_i       = 1'b1;
    bus.req_i   = '0;
    bus.clr_i   = '0;
    bus.data_i  = '0;
    bus.init_i  = '0;
    tick();
    tick();
    rst_i = 1'b0;
  endtask

  // Whole-byte CRC: table[crc ^ byte] computed by eight plain shifts.
  function automatic logic [7:0] crc8(input logic [7:0] c, input logic [7:0] d);
    logic [7:0] r;
    r = c ^ d;
    for (int i = 0; i < 8; i++) r = r[7] ? ({r[6:0], 1'b0} ^ 8'h07) : {r[6:0], 1'b0};
    return r;
  endfunction

  function automatic int pick(input logic [N-1:0] e, input int last);
    int w;
    w = -1;
`ifdef CRC_ARB_PRIO_EN
    for (int i = 0; i < N; i++) if (e[i] && w < 0) w = i;
`else
    for (int i = 1; i <= N; i++) if (e[(last + i) % N] && w < 0) w = (last + i) % N;
`endif
    return w;
  endfunction

  function automatic int onehot_idx(input logic [N-1:0] v);
    int idx;
    idx = -1;
    for (int i = 0; i < N; i++) if (v[i]) idx = (idx == -1) ? i : 99;
    return idx;
  endfunction

  task automatic wait_gnt(output bit got);
    got = 1'b0;
    for (int t = 0; t < 12 && !got; t++) begin
      @(negedge clk_i);
      if (bus.gnt_o != '0) got = 1'b1;
      else tick();
    end
  endtask

  initial begin
    int          n, dones, first, last, lat, k, w, m_last, m_cnt, m_act;
    bit          got, seen;
    logic [N-1:0] pend, clr, exp_gnt, exp_done;
    logic [7:0]  pbyte [N];
    logic [7:0]  m_ctx [N];
    logic [7:0]  m_start, m_byte;

    vecs[0] = '{0, 8'h00, 8'h01, 8'h07};
    vecs[1] = '{1, 8'hFF, 8'h00, 8'hF3};
    vecs[2] = '{2, 8'h5A, 8'h5A, 8'h00};
    vecs[3] = '{3, 8'h00, 8'h80, 8'h89};
    vecs[4] = '{0, 8'h12, 8'h02, 8'h70};
    vecs[5] = '{1, 8'h03, 8'h01, 8'h0E};

    do_reset();
    @(negedge clk_i);
    check("rst_gnt", 32'(bus.gnt_o), 0);
    check("rst_done", 32'(bus.done_o), 0);
    check("rst_busy", 32'(bus.busy_o), 0);
    check("rst_crc", bus.crc_o, 0);
    tick();

    for (int v = 0; v < 6; v++) begin
      k = vecs[v].k;
      bus.clr_i  = N'(1 << k);
      bus.init_i = vecs[v].init;
      tick();
      bus.clr_i = '0;
      bus.req_i = N'(1 << k);
      bus.data_i[8*k +: 8] = vecs[v].dat;
      wait_gnt(got);
      check("tbl_gnt", 32'(bus.gnt_o), 32'(1 << k));
      tick();
      bus.req_i = '0;
      lat = 1;
      @(negedge clk_i);
      while (bus.done_o == '0 && lat < 10) begin
        tick();
        lat++;
        @(negedge clk_i);
      end
      check("tbl_latency", lat, 5);
      check("tbl_done", 32'(bus.done_o), 32'(1 << k));
      check("tbl_crc", 32'(bus.crc_o[8*k +: 8]), 32'(vecs[v].exp));
      tick();
    end

    // "123456789" streamed back-to-back through requester 2.
    bus.clr_i  = 4'b0100;
    bus.init_i = 8'h00;
    tick();
    bus.clr_i = '0;
    n = 0; dones = 0; first = -1; last = -1;
    bus.req_i = 4'b0100;
    bus.data_i[23:16] = 8'h31;
    for (int t = 0; t < 200 && dones < 9; t++) begin
      @(negedge clk_i);
      if (bus.gnt_o[2]) begin
        if (first < 0) first = cyc;
        n++;
      end
      if (bus.done_o[2]) begin
        dones++;
        last = cyc;
      end
      tick();
      if (n < 9) bus.data_i[23:16] = 8'h31 + 8'(n);
      else bus.req_i = '0;
    end
    @(negedge clk_i);
    check("str_crc", 32'(bus.crc_o[23:16]), 32'hF4);
    check("str_dones", dones, 9);
    check("str_span", last - first + 1, 54);
    tick();

    // All four requesting continuously.
    do_reset();
    bus.req_i  = 4'b1111;
    bus.data_i = 32'h44332211;
    for (int g = 0; g < 5; g++) begin
      wait_gnt(got);
`ifdef CRC_ARB_PRIO_EN
      check("arb_order", onehot_idx(bus.gnt_o), 0);
`else
      check("arb_order", onehot_idx(bus.gnt_o), g % N);
`endif
      tick();
    end
    bus.req_i = '0;
    repeat (8) tick();

    // Clear of the active requester while in SHIFT2.
    bus.req_i = 4'b1000;
    bus.data_i[31:24] = 8'h77;
    wait_gnt(got);
    check("abort_gnt", 32'(bus.gnt_o), 32'h8);
    tick();
    bus.req_i = '0;
    tick();
    bus.clr_i  = 4'b1000;
    bus.init_i = 8'h5A;
    @(negedge clk_i);
    check("abort_done_s2", 32'(bus.done_o), 0);
    tick();
    bus.clr_i = '0;
    @(negedge clk_i);
    check("abort_idle", 32'(bus.busy_o), 0);
    check("abort_crc", 32'(bus.crc_o[31:24]), 32'h5A);
    seen = 1'b0;
    for (int t = 0; t < 8; t++) begin
      tick();
      @(negedge clk_i);
      if (bus.done_o != '0) seen = 1'b1;
    end
    check("abort_no_done", 32'(seen), 0);
    tick();

    // Reset while in SHIFT3.
    bus.req_i = 4'b0010;
    bus.data_i[15:8] = 8'h99;
    wait_gnt(got);
    check("rstmid_gnt", 32'(bus.gnt_o), 32'h2);
    tick();
    bus.req_i = '0;
    tick();
    tick();
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    @(negedge clk_i);
    check("rstmid_busy", 32'(bus.busy_o), 0);
    check("rstmid_crc", bus.crc_o, 0);
    seen = 1'b0;
    for (int t = 0; t < 8; t++) begin
      if (bus.done_o != '0) seen = 1'b1;
      tick();
      @(negedge clk_i);
    end
    check("rstmid_no_done", 32'(seen), 0);
    tick();

    // Randomized traffic against a transaction-level model.
    do_reset();
    pend = '0;
    m_last = N - 1; m_cnt = 0; m_act = 0; m_start = '0; m_byte = '0;
    for (int i = 0; i < N; i++) begin
      m_ctx[i] = '0;
      pbyte[i] = '0;
    end
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < N; i++) begin
        if (!pend[i] && $urandom_range(3) == 0) begin
          pend[i]  = 1'b1;
          pbyte[i] = 8'($urandom);
        end
      end
      clr = '0;
      for (int i = 0; i < N; i++) if ($urandom_range(39) == 0) clr[i] = 1'b1;
      bus.req_i = pend;
      for (int i = 0; i < N; i++) bus.data_i[8*i +: 8] = pbyte[i];
      bus.clr_i  = clr;
      bus.init_i = 8'($urandom);

      exp_gnt = '0; exp_done = '0; w = -1;
      if (m_cnt == 0) begin
        w = pick(pend & ~clr, m_last);
        if (w >= 0) exp_gnt[w] = 1'b1;
      end else if (m_cnt == 5 && !clr[m_act]) begin
        exp_done[m_act] = 1'b1;
      end

      @(negedge clk_i);
      check("rnd_gnt", 32'(bus.gnt_o), 32'(exp_gnt));
      check("rnd_done", 32'(bus.done_o), 32'(exp_done));
      check("rnd_busy", 32'(bus.busy_o), 32'(m_cnt != 0));
      if (m_cnt == 0) check("rnd_ctx", bus.crc_o, {m_ctx[3], m_ctx[2], m_ctx[1], m_ctx[0]});
      if (exp_done != '0) check("rnd_done_crc", 32'(bus.crc_o[8*m_act +: 8]), 32'(crc8(m_start, m_byte)));

      if (exp_done != '0) m_ctx[m_act] = crc8(m_start, m_byte);
      if (m_cnt == 0) begin
        if (w >= 0) begin
          m_act   = w;
          m_start = m_ctx[w];
          m_byte  = pbyte[w];
          m_last  = w;
          pend[w] = 1'b0;
          m_cnt   = 1;
        end
      end else if (clr[m_act] || m_cnt == 5) begin
        m_cnt = 0;
      end else begin
        m_cnt++;
      end
      for (int i = 0; i < N; i++) if (clr[i]) m_ctx[i] = bus.init_i;
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
